// File: rtl/aes_out_stream_pkg.sv
// ---------------------------------------------------------------------------
// aes_out_stream_pkg : shared AES stream widths and output FSM encoding. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_out_stream_pkg;

  localparam int AES_BLK_S  = 128;
  localparam int AES_WORD_S = 32;
  localparam int AES_DEPTH  = 2;

  typedef enum logic [0:0] {
    OUT_IDLE = 1'b0,
    OUT_SEND = 1'b1
  } out_state_e;

endpackage

`default_nettype wire

// File: rtl/aes_blk_fifo.sv
// ---------------------------------------------------------------------------
// aes_blk_fifo : DEPTH-entry cipher block buffer, wrap-bit pointers. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_blk_fifo
  import aes_out_stream_pkg::*;
#(
  parameter int WIDTH = AES_BLK_S,
  parameter int DEPTH = AES_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [0:WIDTH-1] wdata_i,
  output logic [0:WIDTH-1] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             one_left_o
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [0:WIDTH-1] mem_q [DEPTH];
  logic [PTR_W:0]   wptr_q, wptr_d;
  logic [PTR_W:0]   rptr_q, rptr_d;

  always_comb begin
    wptr_d = push_i ? wptr_q + PTR_ONE : wptr_q;
    rptr_d = pop_i  ? rptr_q + PTR_ONE : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q[PTR_W-1:0]] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[rptr_q[PTR_W-1:0]];
  assign empty_o    = (wptr_q == rptr_q);
  assign full_o     = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign one_left_o = ((wptr_q - rptr_q) == PTR_ONE);

endmodule

`default_nettype wire

// File: rtl/aes_out_stream.sv
// ---------------------------------------------------------------------------
// aes_out_stream : buffers cipher blocks and streams them as AXI-S words. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_out_stream
  import aes_out_stream_pkg::*;
#(
  parameter int BLK_S  = AES_BLK_S,
  parameter int WORD_S = AES_WORD_S,
  parameter int DEPTH  = AES_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [0:BLK_S-1]  aes_ciphertext,
  output logic [WORD_S-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              overflow
);

  localparam int               N_WORDS  = BLK_S / WORD_S;
  localparam int               CNT_W    = $clog2(N_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  out_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;

  logic             fifo_full, fifo_empty, fifo_one_left;
  logic [0:BLK_S-1] head_blk;
  logic             push, pop, xfer, last_word, send;
  logic [WORD_S-1:0] head_words [N_WORDS];

  aes_blk_fifo #(
    .WIDTH (BLK_S),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .pop_i      (pop),
    .wdata_i    (aes_ciphertext),
    .rdata_o    (head_blk),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .one_left_o (fifo_one_left)
  );

  // Block bit 0 is the first transmitted bit, so word k starts at bit k*WORD_S.
  generate
    for (genvar k = 0; k < N_WORDS; k++) begin : g_words
      assign head_words[k] = head_blk[k*WORD_S +: WORD_S];
    end
  endgenerate

  assign send      = (state_q == OUT_SEND);
  assign xfer      = send && m_axis_tready;
  assign last_word = (cnt_q == CNT_LAST);
  assign pop       = xfer && last_word;
  // A full buffer still accepts when the head block leaves in the same cycle.
  assign push      = en && (!fifo_full || pop);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q | (en & ~push);
    case (state_q)
      OUT_IDLE: begin
        if (push || !fifo_empty) begin
          state_d = OUT_SEND;
        end
      end
      OUT_SEND: begin
        if (xfer) begin
          if (last_word) begin
            cnt_d = '0;
            if (fifo_one_left && !push) begin
              state_d = OUT_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OUT_IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_axis_tvalid = send;
  assign m_axis_tdata  = send ? head_words[cnt_q] : '0;
  assign m_axis_tlast  = send && last_word;
  assign busy          = !fifo_empty || send;
  assign overflow      = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_out_stream.sv
// ---------------------------------------------------------------------------
// tb_aes_out_stream : directed self-checking bench for aes_out_stream. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_out_stream;

  localparam int BLK_S  = 128;
  localparam int WORD_S = 32;
  localparam int DEPTH  = 2;

  localparam logic [127:0] BLK_A = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] BLK_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BLK_C = 128'h00112233445566778899aabbccddeeff;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [0:BLK_S-1]  aes_ciphertext;
  logic [WORD_S-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              busy;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_out_stream #(
    .BLK_S  (BLK_S),
    .WORD_S (WORD_S),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .aes_ciphertext (aes_ciphertext),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .busy           (busy),
    .overflow       (overflow)
  );

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int k);
    return blk[127 - 32*k -: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; m_axis_tready = 1'b0; aes_ciphertext = '0;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid);
    end
    n_checks++;
    if (m_axis_tlast !== 1'b0) begin
      n_fail++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast);
    end
    n_checks++;
    if (m_axis_tdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_tdata: got %h want 00000000", m_axis_tdata);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow);
    end
  endtask

  task automatic test_single();
    m_axis_tready = 1'b1;
    aes_ciphertext = BLK_A; en = 1'b1;
    step();
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word_of(BLK_A, k) ||
          m_axis_tlast !== (k == 3) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_w%0d: got v=%b d=%h l=%b busy=%b want v=1 d=%h l=%b busy=1",
                 k, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, word_of(BLK_A, k), (k == 3));
      end
      step();
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_end: got v=%b busy=%b want v=0 busy=0", m_axis_tvalid, busy);
    end
  endtask

  task automatic test_backpressure();
    m_axis_tready = 1'b1;
    aes_ciphertext = BLK_A; en = 1'b1;
    step();
    en = 1'b0;
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word_of(BLK_A, 0)) begin
      n_fail++; $display("FAIL bp_w0: got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, word_of(BLK_A, 0));
    end
    step();
    for (int h = 0; h < 3; h++) begin
      m_axis_tready = 1'b0;
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h571420f6 || m_axis_tlast !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%h l=%b want v=1 d=571420f6 l=0",
                 h, m_axis_tvalid, m_axis_tdata, m_axis_tlast);
      end
      step();
    end
    m_axis_tready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word_of(BLK_A, k) || m_axis_tlast !== (k == 3)) begin
        n_fail++;
        $display("FAIL bp_w%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 k, m_axis_tvalid, m_axis_tdata, m_axis_tlast, word_of(BLK_A, k), (k == 3));
      end
      step();
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL bp_end: got v=%b want v=0", m_axis_tvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk;
    m_axis_tready = 1'b1;
    aes_ciphertext = BLK_A; en = 1'b1;
    step();
    aes_ciphertext = BLK_B; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      blk = (i < 4) ? BLK_A : BLK_B;
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word_of(blk, i % 4) ||
          m_axis_tlast !== ((i % 4) == 3)) begin
        n_fail++;
        $display("FAIL b2b_w%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, word_of(blk, i % 4), ((i % 4) == 3));
      end
      step();
      en = 1'b0;
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got v=%b busy=%b want v=0 busy=0", m_axis_tvalid, busy);
    end
  endtask

  task automatic test_overflow();
    logic [127:0] blk;
    m_axis_tready = 1'b0;
    aes_ciphertext = BLK_A; en = 1'b1;
    step();
    aes_ciphertext = BLK_B;
    step();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_before: got %b want 0", overflow);
    end
    aes_ciphertext = BLK_C;
    step();
    en = 1'b0;
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b want 1", overflow);
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      blk = (i < 4) ? BLK_A : BLK_B;
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word_of(blk, i % 4) ||
          m_axis_tlast !== ((i % 4) == 3)) begin
        n_fail++;
        $display("FAIL ovf_w%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, word_of(blk, i % 4), ((i % 4) == 3));
      end
      step();
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_end: got v=%b ovf=%b want v=0 ovf=1", m_axis_tvalid, overflow);
    end
    do_reset();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_pop_push();
    logic [127:0] blk;
    m_axis_tready = 1'b0;
    aes_ciphertext = BLK_A; en = 1'b1;
    step();
    aes_ciphertext = BLK_B;
    step();
    en = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word_of(BLK_A, k) || m_axis_tlast !== (k == 3)) begin
        n_fail++;
        $display("FAIL pp_a%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 k, m_axis_tvalid, m_axis_tdata, m_axis_tlast, word_of(BLK_A, k), (k == 3));
      end
      if (k == 3) begin
        aes_ciphertext = BLK_C; en = 1'b1;
      end
      step();
      en = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      blk = (i < 4) ? BLK_B : BLK_C;
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word_of(blk, i % 4) ||
          m_axis_tlast !== ((i % 4) == 3) || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL pp_w%0d: got v=%b d=%h l=%b ovf=%b want v=1 d=%h l=%b ovf=0",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, overflow, word_of(blk, i % 4), ((i % 4) == 3));
      end
      step();
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL pp_end: got v=%b ovf=%b want v=0 ovf=0", m_axis_tvalid, overflow);
    end
  endtask

  task automatic test_reset_mid();
    m_axis_tready = 1'b1;
    aes_ciphertext = BLK_A; en = 1'b1;
    step();
    aes_ciphertext = BLK_B; en = 1'b1;
    step();
    en = 1'b0;
    step();
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word_of(BLK_A, 2)) begin
      n_fail++; $display("FAIL rm_w2: got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, word_of(BLK_A, 2));
    end
    reset = 1'b1; aes_ciphertext = BLK_C; en = 1'b1;
    step();
    reset = 1'b0; en = 1'b0;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_tdata !== 32'h0 || m_axis_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_after: got v=%b busy=%b d=%h l=%b want v=0 busy=0 d=00000000 l=0",
               m_axis_tvalid, busy, m_axis_tdata, m_axis_tlast);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rm_quiet%0d: got v=%b busy=%b want v=0 busy=0", c, m_axis_tvalid, busy);
      end
    end
    aes_ciphertext = BLK_C; en = 1'b1;
    step();
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word_of(BLK_C, k) || m_axis_tlast !== (k == 3)) begin
        n_fail++;
        $display("FAIL rm_fresh%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 k, m_axis_tvalid, m_axis_tdata, m_axis_tlast, word_of(BLK_C, k), (k == 3));
      end
      step();
    end
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL rm_end: got v=%b want v=0", m_axis_tvalid);
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    m_axis_tready = 1'b0;
    aes_ciphertext = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_pop_push();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
